// File: rtl/gb_link_pkg.sv
// Shared types and constants for the handheld link-port peer.
package gb_link_pkg;

    typedef enum logic {
        StIdle,
        StActive
    } link_state_e;

    // Bits exchanged per transfer.
    localparam int unsigned LINK_BITS = 8;

    // Byte shifted out when nothing is queued (reads as "no partner").
    localparam logic [LINK_BITS-1:0] DEF_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/gb_link_clkgen.sv
// Link clock generator for master mode: 8 low/high pairs ending high,
// then the pad output enable held one extra half-period before release.
module gb_link_clkgen
    import gb_link_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             oe_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam int unsigned IdxW    = $clog2(2 * LINK_BITS);
    localparam int unsigned LastIdx = 2 * LINK_BITS - 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             clk_q, clk_d;
    logic             oe_q, oe_d;
    logic [DIV_W-1:0] reload;
    logic             expire;

    // A divider of zero behaves like one.
    assign reload = (div_i == '0) ? DIV_W'(1) : div_i;
    assign expire = oe_q && (cnt_q == DIV_W'(1));

    // Half-period countdown; each expiry either toggles the clock or, on the
    // last one, releases the pad.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        clk_d  = clk_q;
        oe_d   = oe_q;
        rise_o = 1'b0;
        fall_o = 1'b0;
        if (start_i && !oe_q) begin
            // The start cycle itself is the first falling edge.
            clk_d = 1'b0;
            oe_d  = 1'b1;
            cnt_d = reload;
            idx_d = '0;
        end else if (oe_q) begin
            if (expire) begin
                cnt_d = reload;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(LastIdx)) begin
                    oe_d = 1'b0;
                end else begin
                    clk_d  = ~clk_q;
                    rise_o = ~clk_q;
                    fall_o = clk_q;
                end
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    // Generator state register; the clock idles high with the pad released.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            clk_q <= 1'b1;
            oe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            clk_q <= clk_d;
            oe_q  <= oe_d;
        end
    end

    assign clk_o = clk_q;
    assign oe_o  = oe_q;

endmodule

// File: rtl/gb_link_peer.sv
// Far-end emulation of the handheld serial link port. One byte per transfer,
// MSB first; data changes after falling edges and is sampled on rising edges.
module gb_link_peer
    import gb_link_pkg::*;
#(
    parameter logic [LINK_BITS-1:0] IDLE_BYTE   = DEF_IDLE_BYTE,
    parameter int unsigned          TIMEOUT_CYC = 65536,
    parameter int unsigned          DIV_W       = 16
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 master_en_i,
    input  logic [DIV_W-1:0]     clk_half_div_i,
    input  logic                 link_clk_in_i,
    output logic                 link_clk_out_o,
    output logic                 link_clk_oe_o,
    input  logic                 link_sin_i,
    output logic                 link_sout_o,
    input  logic [LINK_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [LINK_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BitW = $clog2(LINK_BITS + 1);

    logic [1:0]           clk_sync_q;
    logic                 clk_dly_q;
    logic [1:0]           sin_sync_q;
    link_state_e          state_q, state_d;
    logic                 mode_q, mode_d;
    logic [LINK_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [LINK_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic [LINK_BITS-2:0] rx_shreg_q, rx_shreg_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [LINK_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 err_q, err_d;
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic                 f_rise, f_fall;
    logic                 cg_clk, cg_oe, cg_rise, cg_fall, cg_start;
    logic                 follow_start;
    logic                 edge_rise, edge_fall;
    logic                 tmo_hit;
    logic [LINK_BITS-1:0] rx_byte;

    gb_link_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .pclk    (pclk),
        .reset_n (reset_n),
        .start_i (cg_start),
        .div_i   (clk_half_div_i),
        .clk_o   (cg_clk),
        .oe_o    (cg_oe),
        .rise_o  (cg_rise),
        .fall_o  (cg_fall)
    );

    // Follower edges: synced clock against a one-cycle delayed copy.
    assign f_rise = clk_sync_q[1] & ~clk_dly_q;
    assign f_fall = ~clk_sync_q[1] & clk_dly_q;

    // Master waits for the previous pad release and never runs on IDLE_BYTE.
    assign cg_start     = (state_q == StIdle) && master_en_i && hold_full_q && !cg_oe;
    assign follow_start = (state_q == StIdle) && !master_en_i && f_fall;

    // Both edge sources feed the one shift datapath.
    assign edge_rise = (state_q == StActive) && (mode_q ? cg_rise : f_rise);
    assign edge_fall = (state_q == StActive) && (mode_q ? cg_fall : f_fall);

    // A link edge in the expiry cycle wins over the abort.
    assign tmo_hit = (state_q == StActive) && !mode_q && !f_rise && !f_fall &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

    assign rx_byte = {rx_shreg_q, sin_sync_q[1]};

    // Next-state logic for the transfer FSM, holding register and shifters.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shreg_d  = tx_shreg_q;
        rx_shreg_d  = rx_shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        err_d       = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;

        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                mode_d     = master_en_i;
                tx_shreg_d = hold_full_q ? hold_q : IDLE_BYTE;
                bit_cnt_d  = '0;
                tmo_cnt_d  = '0;
                if (cg_start || follow_start) begin
                    // tx_shreg locks on the value loaded above.
                    state_d = StActive;
                    if (hold_full_q) begin
                        hold_full_d = 1'b0;
                    end
                end
            end
            StActive: begin
                tmo_cnt_d = (f_rise || f_fall) ? '0 : tmo_cnt_q + TmoW'(1);
                if (edge_fall && (bit_cnt_q != '0)) begin
                    tx_shreg_d = tx_shreg_q << 1;
                end
                if (edge_rise) begin
                    rx_shreg_d = rx_byte[LINK_BITS-2:0];
                    bit_cnt_d  = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(LINK_BITS - 1)) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = StIdle;
                    end
                end
                if (tmo_hit) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    err_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Two-flop synchronisers for the asynchronous pad inputs.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            clk_dly_q  <= 1'b1;
            sin_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], link_clk_in_i};
            clk_dly_q  <= clk_sync_q[1];
            sin_sync_q <= {sin_sync_q[0], link_sin_i};
        end
    end

    // Transfer state and datapath registers.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shreg_q  <= IDLE_BYTE;
            rx_shreg_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign link_clk_out_o = cg_clk;
    assign link_clk_oe_o  = cg_oe;
    assign link_sout_o    = tx_shreg_q[LINK_BITS-1];
    assign tx_ready_o     = ~hold_full_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign busy_o         = (state_q == StActive);
    assign err_o          = err_q;

endmodule

// File: tb/tb_gb_link_peer.sv
// Bench for gb_link_peer: plays the console side of the link (follower
// transfers) or a loopback pad (master transfers) against a byte-level model.
module tb_gb_link_peer;

    localparam int unsigned TMO = 300;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        master_en = 1'b0;
    logic [15:0] clk_half_div = 16'd4;
    logic        clk_drv = 1'b1;
    logic        sin_drv = 1'b1;
    logic        loopback = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;

    logic        link_clk_in, link_clk_out, link_clk_oe, link_sin, link_sout;
    logic        tx_ready, rx_valid, busy, err;
    logic [7:0]  rx_data;

    int          n_vec = 0;
    int          n_bad = 0;
    int          rx_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  rx_last = 8'h00;

    // Pad model: the clock line reads back whatever is driven onto it.
    assign link_clk_in = link_clk_oe ? link_clk_out : clk_drv;
    assign link_sin    = loopback ? link_sout : sin_drv;

    gb_link_peer #(
        .IDLE_BYTE   (8'hFF),
        .TIMEOUT_CYC (TMO),
        .DIV_W       (16)
    ) dut (
        .pclk           (pclk),
        .reset_n        (reset_n),
        .master_en_i    (master_en),
        .clk_half_div_i (clk_half_div),
        .link_clk_in_i  (link_clk_in),
        .link_clk_out_o (link_clk_out),
        .link_clk_oe_o  (link_clk_oe),
        .link_sin_i     (link_sin),
        .link_sout_o    (link_sout),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 pclk = ~pclk;

    // Count received bytes and error pulses.
    always @(negedge pclk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_last = rx_data;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge pclk);
            t++;
        end
        check("push_ready", 32'(tx_ready), 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        check("tx_ready_drop", 32'(tx_ready), 0);
    endtask

    // Console clocks a byte; the peer's bits are sampled just before each rise.
    task automatic follower_xfer(input logic [7:0] cb, input logic have_tx,
                                 input logic [7:0] tb, input int toggle_bit);
        logic [7:0] exp_tx, got;
        int         half, rx0, oe_seen;
        master_en = 1'b0;
        loopback  = 1'b0;
        exp_tx    = have_tx ? tb : 8'hFF;
        if (have_tx) push(tb);
        rx0     = rx_cnt;
        half    = int'($urandom_range(12, 40));
        oe_seen = 0;
        got     = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clk_drv = 1'b0;
            wait_cyc(half / 2);
            sin_drv = cb[i];
            wait_cyc(half - half / 2);
            got[i] = link_sout;
            if (link_clk_oe) oe_seen++;
            clk_drv = 1'b1;
            if (i == 7) check("fol_tx_ready_after_fall", 32'(tx_ready), 1);
            if (i == toggle_bit) master_en = 1'b1;
            wait_cyc(half);
        end
        wait_cyc(8);
        check("fol_rx_count", 32'(rx_cnt - rx0), 1);
        check("fol_rx_data", 32'(rx_last), 32'(cb));
        check("fol_sout_bits", 32'(got), 32'(exp_tx));
        check("fol_busy_end", 32'(busy), 0);
        if (toggle_bit >= 0) check("fol_no_clk_drive", 32'(oe_seen), 0);
    endtask

    // Master transfer with the data line looped back; clock widths measured.
    task automatic master_xfer(input logic [7:0] b, input logic [15:0] div, input logic chk_rx);
        int   half, rx0, run, rises, bad, tail, t;
        logic prev, done;
        master_en    = 1'b1;
        clk_half_div = div;
        loopback     = 1'b1;
        half         = (div == 16'd0) ? 1 : int'(div);
        rx0          = rx_cnt;
        push(b);
        t = 0;
        while (!link_clk_oe && t < 20) begin
            @(negedge pclk);
            t++;
        end
        check("m_oe_start", 32'(link_clk_oe), 1);
        check("m_clk_low_start", 32'(link_clk_out), 0);
        prev  = link_clk_out;
        run   = 1;
        rises = 0;
        bad   = 0;
        tail  = 0;
        done  = 1'b0;
        t     = 0;
        while (!done && t < 40 * half + 100) begin
            @(negedge pclk);
            t++;
            if (!link_clk_oe) begin
                tail = run;
                done = 1'b1;
            end else if (link_clk_out == prev) begin
                run++;
            end else begin
                if (run != half) bad++;
                if (link_clk_out) rises++;
                prev = link_clk_out;
                run  = 1;
            end
        end
        check("m_finished", 32'(done), 1);
        check("m_rises", 32'(rises), 8);
        check("m_half_widths_bad", 32'(bad), 0);
        check("m_oe_tail", 32'(tail), 32'(half));
        wait_cyc(4);
        check("m_oe_low_after", 32'(link_clk_oe), 0);
        check("m_clk_high_after", 32'(link_clk_out), 1);
        check("m_busy_after", 32'(busy), 0);
        check("m_rx_count", 32'(rx_cnt - rx0), 1);
        if (chk_rx) check("m_rx_data", 32'(rx_last), 32'(b));
        loopback = 1'b0;
    endtask

    initial begin
        int rx0, e0;
        logic [7:0] rb, tb;

        wait_cyc(3);
        check("rst_clk_out", 32'(link_clk_out), 1);
        check("rst_clk_oe", 32'(link_clk_oe), 0);
        check("rst_sout", 32'(link_sout), 1);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        reset_n = 1'b1;
        wait_cyc(4);

        follower_xfer(8'h3C, 1'b1, 8'hA5, -1);
        follower_xfer(8'h00, 1'b0, 8'h00, -1);
        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom());
            tb = 8'($urandom());
            follower_xfer(rb, 1'($urandom_range(0, 1)), tb, -1);
        end

        master_xfer(8'h81, 16'd4, 1'b1);
        master_xfer(8'($urandom()), 16'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            master_xfer(8'($urandom()), 16'($urandom_range(3, 6)), 1'b1);
        end

        // Follower abort after three edges, then a clean byte.
        master_en = 1'b0;
        push(8'h96);
        rx0 = rx_cnt;
        e0  = err_cnt;
        clk_drv = 1'b0;
        wait_cyc(20);
        clk_drv = 1'b1;
        wait_cyc(20);
        clk_drv = 1'b0;
        wait_cyc(20);
        check("tmo_busy_mid", 32'(busy), 1);
        check("tmo_hold_consumed", 32'(tx_ready), 1);
        wait_cyc(TMO - 100);
        check("tmo_not_early", 32'(busy), 1);
        check("tmo_no_err_early", 32'(err_cnt - e0), 0);
        wait_cyc(200);
        check("tmo_err_pulses", 32'(err_cnt - e0), 1);
        check("tmo_busy_after", 32'(busy), 0);
        check("tmo_no_rx", 32'(rx_cnt - rx0), 0);
        clk_drv = 1'b1;
        wait_cyc(20);
        follower_xfer(8'h55, 1'b0, 8'h00, -1);

        // master_en raised mid follower transfer; next transfer is master.
        follower_xfer(8'($urandom()), 1'b1, 8'h5A, 4);
        master_xfer(8'h3C, 16'd4, 1'b1);

        // Reset in the middle of a master transfer.
        master_en    = 1'b1;
        clk_half_div = 16'd5;
        loopback     = 1'b1;
        push(8'hC3);
        wait_cyc(30);
        check("rst_mid_busy_before", 32'(busy), 1);
        rx0 = rx_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_oe", 32'(link_clk_oe), 0);
        check("rst_mid_clk", 32'(link_clk_out), 1);
        check("rst_mid_tx_ready", 32'(tx_ready), 1);
        check("rst_mid_busy", 32'(busy), 0);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(200);
        check("rst_mid_no_rx", 32'(rx_cnt - rx0), 0);
        check("rst_mid_no_restart", 32'(link_clk_oe), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
